// File: rtl/prim_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module      : prim_mux_rr
//  Description : Registered N:1 channel multiplexer with ready/valid
//                handshake. Channel choice is either a fixed select input
//                or a round-robin scan that resumes after the last granted
//                channel. One output word register with full-throughput
//                backpressure handling.
//  Revision    : 1.0 - initial release
// ============================================================================
module prim_mux_rr #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,   // legal range 2..16
    parameter int SELW     = 2    // must satisfy 2**SELW >= CHANNELS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SELW-1:0]           sel,
    input  logic                      mode,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sel_err
);

    // Highest legal channel index; also the pointer reset value so that
    // the first round-robin search starts at channel 0.
    localparam logic [SELW-1:0] c_last_chan = SELW'(CHANNELS - 1);

    logic [WIDTH-1:0]      r_out_data;
    logic [SELW-1:0]       r_out_chan;
    logic                  r_out_valid;
    logic                  r_sel_err;
    logic [SELW-1:0]       r_ptr;

    logic                  w_open;
    logic                  w_sel_oor;
    logic                  w_fix_valid;
    logic                  w_fix_ok;
    logic [2*CHANNELS-1:0] w_dbl;
    logic [CHANNELS-1:0]   w_rot;
    int                    w_off;
    int                    w_rr_pos;
    logic [SELW-1:0]       w_rr_grant;
    logic                  w_rr_ok;
    logic [SELW-1:0]       w_grant;
    logic                  w_grant_ok;
    logic                  w_fire;
    logic [WIDTH-1:0]      w_grant_data;
    logic [CHANNELS-1:0]   w_ready;

    // The output register may take a new word when empty or being drained.
    assign w_open    = !r_out_valid || out_ready;
    assign w_sel_oor = (int'(sel) >= CHANNELS);

    // Fixed-select validity: look up in_valid[sel] without an out-of-range index.
    always_comb begin
        w_fix_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(sel) == i) begin
                w_fix_valid = in_valid[i];
            end
        end
        w_fix_ok = !w_sel_oor && w_fix_valid;
    end

    // Round-robin search: rotate the request vector so bit 0 is ptr+1, take
    // the lowest set bit, then map the offset back modulo CHANNELS. The
    // doubled vector makes the wrap go straight from CHANNELS-1 to 0.
    always_comb begin
        w_dbl = {in_valid, in_valid};
        w_rot = CHANNELS'(w_dbl >> (int'(r_ptr) + 1));
        w_off = 0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = k;
            end
        end
        w_rr_pos = int'(r_ptr) + 1 + w_off;
        if (w_rr_pos >= CHANNELS) begin
            w_rr_pos = w_rr_pos - CHANNELS;
        end
        w_rr_grant = SELW'(w_rr_pos);
        w_rr_ok    = |in_valid;
    end

    // Mode is applied combinationally so a mode change affects this cycle.
    assign w_grant    = mode ? w_rr_grant : sel;
    assign w_grant_ok = mode ? w_rr_ok : w_fix_ok;
    assign w_fire     = w_open && w_grant_ok;

    // Select the granted channel's data word and form the one-hot accept.
    always_comb begin
        w_grant_data = '0;
        w_ready      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(w_grant) == i) begin
                w_grant_data = in_data[i*WIDTH +: WIDTH];
                w_ready[i]   = rst_n && w_fire;
            end
        end
    end

    // Output word register, round-robin pointer and select-error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_sel_err   <= 1'b0;
            r_ptr       <= c_last_chan;
        end else begin
            r_sel_err <= !mode && w_sel_oor;
            if (w_fire) begin
                r_out_data  <= w_grant_data;
                r_out_chan  <= w_grant;
                r_out_valid <= 1'b1;
                if (mode) begin
                    r_ptr <= w_grant;
                end
            end else if (w_open) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_ready;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;
    assign sel_err   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_prim_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prim_mux_rr
//  Description : Self-checking bench for prim_mux_rr. Two instances share
//                stimulus: a 4-channel and a 3-channel build. A behavioural
//                model tracks each instance; directed phases pin the model
//                with literal expectations, then random traffic follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prim_mux_rr;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [1:0]  sel;
    logic        mode;
    logic        out_ready;

    logic [3:0]  ready_a;
    logic [7:0]  data_a;
    logic [1:0]  chan_a;
    logic        valid_a;
    logic        err_a;

    logic [2:0]  ready_b;
    logic [7:0]  data_b;
    logic [1:0]  chan_b;
    logic        valid_b;
    logic        err_b;

    int checks;
    int failures;

    // Behavioural model state, index 0 = 4-channel, index 1 = 3-channel.
    int       nch [2];
    bit       m_v [2];
    bit [7:0] m_d [2];
    int       m_c [2];
    bit       m_e [2];
    int       m_p [2];

    logic [3:0] la_ready;
    logic [2:0] lb_ready;

    prim_mux_rr #(.WIDTH(8), .CHANNELS(4), .SELW(2)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (ready_a),
        .sel       (sel),
        .mode      (mode),
        .out_data  (data_a),
        .out_chan  (chan_a),
        .out_valid (valid_a),
        .out_ready (out_ready),
        .sel_err   (err_a)
    );

    prim_mux_rr #(.WIDTH(8), .CHANNELS(3), .SELW(2)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data[23:0]),
        .in_valid  (in_valid[2:0]),
        .in_ready  (ready_b),
        .sel       (sel),
        .mode      (mode),
        .out_data  (data_b),
        .out_chan  (chan_b),
        .out_valid (valid_b),
        .out_ready (out_ready),
        .sel_err   (err_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Grant chosen by the rules: fixed select, or first valid after ptr.
    function automatic void mgrant(input int j, output int g, output bit ok);
        int n;
        int idx;
        n  = nch[j];
        g  = 0;
        ok = 1'b0;
        if (!mode) begin
            g  = int'(sel);
            ok = (g < n) && in_valid[g];
        end else begin
            for (int k = 1; k <= n; k++) begin
                idx = (m_p[j] + k) % n;
                if (in_valid[idx]) begin
                    g  = idx;
                    ok = 1'b1;
                    break;
                end
            end
        end
    endfunction

    function automatic logic [31:0] exp_ready(input int j);
        int g;
        bit ok;
        bit open;
        open = !m_v[j] || out_ready;
        mgrant(j, g, ok);
        if (rst_n && open && ok) return 32'(1) << g;
        return 32'(0);
    endfunction

    task automatic mupdate(input int j);
        int g;
        bit ok;
        bit open;
        open = !m_v[j] || out_ready;
        mgrant(j, g, ok);
        if (!rst_n) begin
            m_v[j] = 1'b0;
            m_d[j] = 8'h00;
            m_c[j] = 0;
            m_e[j] = 1'b0;
            m_p[j] = nch[j] - 1;
        end else begin
            m_e[j] = !mode && (int'(sel) >= nch[j]);
            if (open && ok) begin
                m_v[j] = 1'b1;
                m_d[j] = in_data[g*8 +: 8];
                m_c[j] = g;
                if (mode) m_p[j] = g;
            end else if (open) begin
                m_v[j] = 1'b0;
            end
        end
    endtask

    // One clock: drive at negedge, check accept lines before the edge,
    // advance the model at the edge, check registered outputs after it.
    task automatic step(input bit rn, input bit md, input logic [1:0] s,
                        input logic [3:0] iv, input logic [31:0] d, input bit ordy);
        @(negedge clk);
        rst_n     = rn;
        mode      = md;
        sel       = s;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        la_ready = ready_a;
        lb_ready = ready_b;
        chk("in_ready_a", 32'(ready_a), exp_ready(0));
        chk("in_ready_b", 32'(ready_b), exp_ready(1));
        @(posedge clk);
        mupdate(0);
        mupdate(1);
        #1;
        chk("out_valid_a", 32'(valid_a), 32'(m_v[0]));
        chk("out_data_a",  32'(data_a),  32'(m_d[0]));
        chk("out_chan_a",  32'(chan_a),  32'(m_c[0]));
        chk("sel_err_a",   32'(err_a),   32'(m_e[0]));
        chk("out_valid_b", 32'(valid_b), 32'(m_v[1]));
        chk("out_data_b",  32'(data_b),  32'(m_d[1]));
        chk("out_chan_b",  32'(chan_b),  32'(m_c[1]));
        chk("sel_err_b",   32'(err_b),   32'(m_e[1]));
    endtask

    initial begin
        logic [2:0] exp_seq_a [5];
        logic [2:0] exp_seq_b [5];
        clk       = 1'b0;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        sel       = '0;
        mode      = 1'b0;
        out_ready = 1'b0;
        checks    = 0;
        failures  = 0;
        nch[0] = 4;
        nch[1] = 3;
        for (int j = 0; j < 2; j++) begin
            m_v[j] = 1'b0; m_d[j] = 8'h00; m_c[j] = 0; m_e[j] = 1'b0; m_p[j] = nch[j] - 1;
        end

        // Reset state.
        step(0, 0, 2'd0, 4'b0000, 32'h0, 1'b0);
        step(0, 1, 2'd0, 4'b1111, 32'h0, 1'b1);
        chk("rst_valid_a", 32'(valid_a), 32'h0);
        chk("rst_ready_a", 32'(la_ready), 32'h0);
        chk("rst_err_b",   32'(err_b),   32'h0);

        // Fixed select of channel 2.
        step(1, 0, 2'd2, 4'b0100, 32'h00A5_0000, 1'b1);
        chk("fix_ready_a", 32'(la_ready), 32'h4);
        chk("fix_valid_a", 32'(valid_a), 32'h1);
        chk("fix_data_a",  32'(data_a),  32'hA5);
        chk("fix_chan_a",  32'(chan_a),  32'h2);

        // Reset with a word held discards it.
        step(0, 0, 2'd2, 4'b0100, 32'h00A5_0000, 1'b0);
        chk("rstheld_valid_a", 32'(valid_a), 32'h0);
        chk("rstheld_data_a",  32'(data_a),  32'h0);

        // Round-robin with all channels requesting, starting at channel 0.
        exp_seq_a = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        exp_seq_b = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1};
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 2'd0, 4'b1111, 32'h4433_2211, 1'b1);
            chk("rr_seq_a", 32'(chan_a), 32'(exp_seq_a[i]));
            chk("rr_seq_b", 32'(chan_b), 32'(exp_seq_b[i]));
        end

        // Sparse requests: move ptr to 1, then 3, 1, then none.
        step(1, 1, 2'd0, 4'b0010, 32'h4433_2211, 1'b1);
        chk("rr_p1_a", 32'(chan_a), 32'h1);
        step(1, 1, 2'd0, 4'b1010, 32'h4433_2211, 1'b1);
        chk("rr_g3_a", 32'(chan_a), 32'h3);
        chk("rr_d3_a", 32'(data_a), 32'h44);
        step(1, 1, 2'd0, 4'b1010, 32'h4433_2211, 1'b1);
        chk("rr_g1_a", 32'(chan_a), 32'h1);
        step(1, 1, 2'd0, 4'b0000, 32'h4433_2211, 1'b1);
        chk("rr_idle_valid_a", 32'(valid_a), 32'h0);
        chk("rr_idle_chan_a",  32'(chan_a),  32'h1);

        // Backpressure: word 11 held for three cycles, then replaced at once.
        step(1, 0, 2'd1, 4'b0010, 32'h0000_1100, 1'b1);
        chk("bp_load_a", 32'(data_a), 32'h11);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 2'd2, 4'b1111, $urandom, 1'b0);
            chk("bp_hold_data_a",  32'(data_a),   32'h11);
            chk("bp_hold_valid_a", 32'(valid_a),  32'h1);
            chk("bp_hold_ready_a", 32'(la_ready), 32'h0);
        end
        step(1, 0, 2'd2, 4'b0100, 32'h0022_0000, 1'b1);
        chk("bp_release_data_a", 32'(data_a), 32'h22);
        chk("bp_release_chan_a", 32'(chan_a), 32'h2);

        // Out-of-range select on the 3-channel build.
        step(1, 0, 2'd3, 4'b1111, 32'h4433_2211, 1'b1);
        chk("oor_err_b",   32'(err_b),    32'h1);
        chk("oor_valid_b", 32'(valid_b),  32'h0);
        chk("oor_data_b",  32'(data_b),   32'h22);
        chk("oor_ready_b", 32'(lb_ready), 32'h0);
        chk("oor_err_a",   32'(err_a),    32'h0);
        chk("oor_data_a",  32'(data_a),   32'h44);
        step(1, 0, 2'd0, 4'b1111, 32'h4433_2211, 1'b1);
        chk("oor_clear_b", 32'(err_b), 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 49) != 0), 1'($urandom), 2'($urandom),
                 4'($urandom), $urandom, ($urandom_range(0, 9) < 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
